// File: rtl/echo_delay_core.sv
// echo_delay_core: mono echo with a block-RAM ring buffer and saturating feedback.
// Audio on channel 0, delay-time CV on channel 1, optional freeze gate on channel 2.
// The freeze feature is built in when ECHO_DELAY_FREEZE_EN is defined.
module echo_delay_core #(
  parameter int W             = 16,
  parameter int AW            = 12,
  parameter int FB_SHIFT      = 1,
  parameter int DEFAULT_DELAY = 2048
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_clk,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  output logic [W-1:0] sample_out0,
  output logic [W-1:0] sample_out1,
  output logic [W-1:0] sample_out2,
  output logic [W-1:0] sample_out3,
  input  logic [7:0]   jack
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_READ, S_UPDATE} state_t;

  state_t         state_q, state_d;
  logic           sample_clk_q;
  logic           tick;
  logic [AW-1:0]  clr_addr_q, clr_addr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [W-1:0]   in0_q, in0_d;
  logic [W-1:0]   out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;

  logic [W-1:0]   mem [DEPTH];
  logic [W-1:0]   wet_q;
  logic           ram_we;
  logic [AW-1:0]  ram_waddr;
  logic [W-1:0]   ram_wdata;

  logic [W-1:0]   cv_u;
  logic [AW-1:0]  dly;
  logic signed [W-1:0] wet_s, in0_s, wet_fb, mix;
  logic signed [W:0]   fb_sum;
  logic [W-1:0]   fb;
  logic           frozen;
  logic           unused_ok;

  assign tick = sample_clk & ~sample_clk_q;

`ifdef ECHO_DELAY_FREEZE_EN
  localparam logic signed [W-1:0] FREEZE_THRESH = W'(4000);
  logic frozen_q;

  // Capture the freeze decision for the tick being processed.
  always_ff @(posedge clk) begin
    if (rst) frozen_q <= 1'b0;
    else if (state_q == S_IDLE && tick)
      frozen_q <= jack[2] && ($signed(sample_in2) > FREEZE_THRESH);
  end
  assign frozen    = frozen_q;
  assign unused_ok = ^{sample_in3, jack[7:3], jack[0], cv_u[W-AW-1:0]};
`else
  assign frozen    = 1'b0;
  assign unused_ok = ^{sample_in2, sample_in3, jack[7:2], jack[0], cv_u[W-AW-1:0]};
`endif

  // Delay in samples from the CV (offset binary, top AW bits) or the default.
  always_comb begin
    cv_u = {~sample_in1[W-1], sample_in1[W-2:0]};
    if (!jack[1]) dly = AW'(DEFAULT_DELAY);
    else          dly = cv_u[W-1:W-AW];
    if (dly == '0) dly = AW'(1);
  end

  // Feedback node with saturation, and the half/half output mix.
  always_comb begin
    wet_s  = $signed(wet_q);
    in0_s  = $signed(in0_q);
    wet_fb = wet_s >>> FB_SHIFT;
    fb_sum = $signed({in0_s[W-1], in0_s}) + $signed({wet_fb[W-1], wet_fb});
    if (fb_sum[W] != fb_sum[W-1]) fb = fb_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                          fb = fb_sum[W-1:0];
    mix = (in0_s >>> 1) + (wet_s >>> 1);
  end

  // FSM next-state, RAM write port and output register updates.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_addr_d  = rd_addr_q;
    in0_d      = in0_q;
    out0_d     = out0_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    out3_d     = out3_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_ptr_q;
    ram_wdata  = fb;
    case (state_q)
      S_CLEAR: begin
        ram_we     = 1'b1;
        ram_waddr  = clr_addr_q;
        ram_wdata  = '0;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (tick) begin
          in0_d     = sample_in0;
          rd_addr_d = wr_ptr_q - dly;
          state_d   = S_READ;
        end
      end
      S_READ: state_d = S_UPDATE;
      S_UPDATE: begin
        out0_d   = mix;
        out1_d   = wet_q;
        out2_d   = in0_q;
        out3_d   = frozen ? wet_q : fb;
        ram_we   = ~frozen;
        wr_ptr_d = wr_ptr_q + AW'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      sample_clk_q <= 1'b0;
      clr_addr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_addr_q    <= '0;
      in0_q        <= '0;
      out0_q       <= '0;
      out1_q       <= '0;
      out2_q       <= '0;
      out3_q       <= '0;
    end else begin
      state_q      <= state_d;
      sample_clk_q <= sample_clk;
      clr_addr_q   <= clr_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_addr_q    <= rd_addr_d;
      in0_q        <= in0_d;
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      out2_q       <= out2_d;
      out3_q       <= out3_d;
    end
  end

  // Ring buffer: one write port, registered read; contents are only cleared by the sweep.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) mem[ram_waddr] <= ram_wdata;
    wet_q <= mem[rd_addr_q];
  end

  assign sample_out0 = out0_q;
  assign sample_out1 = out1_q;
  assign sample_out2 = out2_q;
  assign sample_out3 = out3_q;

endmodule

// File: tb/tb_echo_delay_core.sv
// Testbench for echo_delay_core: directed vectors plus a behavioural ring-buffer model.
module tb_echo_delay_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_clk = 1'b0;
  logic [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [15:0] out0, out1, out2, out3;
  logic [7:0]  jack = '0;

  always #5 clk = ~clk;

  echo_delay_core #(.W(16), .AW(12), .FB_SHIFT(1), .DEFAULT_DELAY(2048)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
    .sample_out0(out0), .sample_out1(out1), .sample_out2(out2), .sample_out3(out3),
    .jack(jack)
  );

  int checks = 0;
  int errors = 0;
  int m [4096];
  int wp;
  int e0, e1, e2, e3;

  typedef struct {
    int a0; int a1; int a2; logic [7:0] j;
    int x0; int x1; int x2; int x3;
  } vec_t;
  vec_t tbl [10];

`ifdef ECHO_DELAY_FREEZE_EN
  localparam int FRZ_N = 600;
`else
  localparam int FRZ_N = 40;
`endif

  function automatic int so(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One sample tick: sample_clk high for two clk cycles, low for two.
  task automatic apply(input int a0, input int a1, input int a2, input logic [7:0] j);
    @(negedge clk);
    in0 = 16'(a0); in1 = 16'(a1); in2 = 16'(a2); jack = j;
    sample_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sample_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic model(input int a0, input int a1, input int a2, input logic [7:0] j);
    int d, rd, wet, fbv;
    bit frz;
    if (!j[1]) d = 2048;
    else       d = (a1 + 32768) >> 4;
    if (d == 0) d = 1;
    rd  = (wp - d + 4096) % 4096;
    wet = m[rd];
    fbv = a0 + (wet >>> 1);
    if (fbv > 32767)  fbv = 32767;
    if (fbv < -32768) fbv = -32768;
`ifdef ECHO_DELAY_FREEZE_EN
    frz = j[2] && (a2 > 4000);
`else
    frz = 1'b0;
`endif
    e0 = (a0 >>> 1) + (wet >>> 1);
    e1 = wet;
    e2 = a0;
    e3 = frz ? wet : fbv;
    if (!frz) m[wp] = fbv;
    wp = (wp + 1) % 4096;
  endtask

  task automatic tick_model(input string tag, input int a0, input int a1, input int a2,
                            input logic [7:0] j);
    apply(a0, a1, a2, j);
    model(a0, a1, a2, j);
    chk({tag, "_out0"}, so(out0), e0);
    chk({tag, "_out1"}, so(out1), e1);
    chk({tag, "_out2"}, so(out2), e2);
    chk({tag, "_out3"}, so(out3), e3);
  endtask

  initial begin
    tbl[0] = '{1000,   -32768, 0, 8'h03,   1500,   2000,   1000,   2000};
    tbl[1] = '{-500,   -32768, 0, 8'h03,    750,   2000,   -500,    500};
    tbl[2] = '{30000,  -32768, 0, 8'h03,  15250,    500,  30000,  30250};
    tbl[3] = '{30000,  -32768, 0, 8'h03,  30125,  30250,  30000,  32767};
    tbl[4] = '{30000,  -32768, 0, 8'h03,  31383,  32767,  30000,  32767};
    tbl[5] = '{-30000, -32768, 0, 8'h03,   1383,  32767, -30000, -13617};
    tbl[6] = '{-30000, -32768, 0, 8'h03, -21809, -13617, -30000, -32768};
    tbl[7] = '{-30000, -32768, 0, 8'h03, -31384, -32768, -30000, -32768};
    tbl[8] = '{0,      -32640, 0, 8'h03,   1000,   2000,      0,   1000};
    tbl[9] = '{100,    -32640, 0, 8'h01,     50,      0,    100,    100};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out0", so(out0), 0);
    chk("rst_out1", so(out1), 0);
    chk("rst_out2", so(out2), 0);
    chk("rst_out3", so(out3), 0);
    rst = 1'b0;

    // Ticks during CLEAR are dropped; reset mid-CLEAR restarts the sweep
    repeat (100) @(negedge clk);
    apply(1234, 0, 0, 8'h01);
    chk("clear_drop_out2", so(out2), 0);
    repeat (1900) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4000) @(negedge clk);
    apply(555, 0, 0, 8'h01);
    chk("clear_restart_out2", so(out2), 0);
    repeat (200) @(negedge clk);

    foreach (m[i]) m[i] = 0;
    wp = 0;

    // Impulse with default delay and feedback decay
    tick_model("imp", 16000, 0, 0, 8'h01);
    chk("first_after_clear_out1", so(out1), 0);
    for (int n = 1; n <= 6144; n++) begin
      tick_model("decay", 0, 0, 0, 8'h01);
      if (n == 2048) begin
        chk("echo1_out1", so(out1), 16000);
        chk("echo1_out0", so(out0), 8000);
      end
      if (n == 4096) chk("echo2_out1", so(out1), 8000);
      if (n == 6144) chk("echo3_out1", so(out1), 4000);
    end

    // Directed vectors: d=1, saturation both ways, CV-derived delay, jack[1] gating
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].j);
      model(tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].j);
      chk($sformatf("vec%0d_out0", i), so(out0), tbl[i].x0);
      chk($sformatf("vec%0d_out1", i), so(out1), tbl[i].x1);
      chk($sformatf("vec%0d_out2", i), so(out2), tbl[i].x2);
      chk($sformatf("vec%0d_out3", i), so(out3), tbl[i].x3);
    end

    // Maximum delay across the write-pointer wrap
    for (int n = 0; n < 4300; n++) tick_model("dmax", n % 1000, 32767, 0, 8'h03);

    // Mid-scale CV gives d=2048, signed input pattern
    for (int n = 0; n < 300; n++) tick_model("dmid", (n % 700) - 350, 0, 0, 8'h03);

    // Freeze gate (ignored unless the feature is built in)
    for (int n = 0; n < FRZ_N; n++) tick_model("frz", 0, 0, 10000, 8'h05);
    for (int n = 0; n < FRZ_N / 2; n++) tick_model("unfrz", 0, 0, 0, 8'h05);

    // Reset mid-operation: buffer must be re-cleared and pointer restarted
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_out3", so(out3), 0);
    rst = 1'b0;
    repeat (4200) @(negedge clk);
    foreach (m[i]) m[i] = 0;
    wp = 0;
    tick_model("post_rst", 7, -32768, 0, 8'h03);
    chk("post_rst_cleared_out1", so(out1), 0);
    for (int n = 0; n < 20; n++) tick_model("post_rst_run", n * 100, 32767, 0, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
